seq_pattern_tx: RTL

Serial pattern transmitter that generates framed bitstreams for the sequence-detector FSMs in `src/fsm/sequence_detector`. It is the stimulus end of the detector interface: on a start request it latches a W-bit pattern and shifts it out MSB first on `aout`, one bit per clock. The pattern repeats a programmed number of times, with an optional run of idle zeros between repetitions. Its `aout` drives a detector's `ain` directly, and `aout_vld`, `sof` and `done` give frame visibility to the bench or the downstream logic.

---
 rtl/seq_pattern_tx_if.sv | 44 ++++
 rtl/seq_pattern_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx_if
//   Bundle of request, configuration and serial-output signals between the
//   pattern transmitter and whoever drives and observes it.
//
//   Request/config (master -> slave):
//     start     : begin a run (honoured only while the transmitter is idle)
//     abort     : synchronous cancel, highest priority
//     pat_in    : W-bit pattern, bit W-1 is sent first
//     repeat_n  : number of repetitions (0 means the start is ignored)
//     gap_len   : idle cycles inserted between repetitions
//   Stream/status (slave -> master):
//     aout      : serial data, forced to 0 when aout_vld is low
//     aout_vld  : aout carries a pattern bit
//     sof       : first bit of each repetition
//     busy      : a run is in progress
//     done      : one-cycle pulse after the last bit of the last repetition
// -----------------------------------------------------------------------------
interface seq_pattern_tx_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [W-1:0]     pat_in;
  logic [CNT_W-1:0] repeat_n;
  logic [3:0]       gap_len;

  logic             aout;
  logic             aout_vld;
  logic             sof;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pat_in, repeat_n, gap_len,
    input  aout, aout_vld, sof, busy, done
  );

  modport slave (
    input  start, abort, pat_in, repeat_n, gap_len,
    output aout, aout_vld, sof, busy, done
  );
endinterface : seq_pattern_tx_if

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial pattern transmitter feeding sequence-detector FSMs. On an accepted
//   start it latches a W-bit pattern, a repetition count and a gap length, then
//   shifts the pattern out MSB first, one bit per clock, repeating it the
//   requested number of times with optional idle zeros in between.
//
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous, active-low reset
//     bus : seq_pattern_tx_if.slave (request/config in, stream/status out)
//
//   All outputs are registered. They are computed from the next-state values,
//   so the cycle after the accepting edge already carries the first bit.
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);

  localparam int          BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIDX_TOP = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [W-1:0]     sh_q,     sh_d;
  logic [W-1:0]     pat_q,    pat_d;
  logic [BW-1:0]    bidx_q,   bidx_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic [3:0]       gcnt_q,   gcnt_d;
  logic [3:0]       gap_q,    gap_d;

  logic             aout_q,   aout_d;
  logic             vld_q,    vld_d;
  logic             sof_q,    sof_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path through
    // this block leaves a signal unassigned and no latch can be inferred.
    state_d = state_q;
    sh_d    = sh_q;
    pat_d   = pat_q;
    bidx_d  = bidx_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    if (bus.abort) begin
      // Cancel from any state; the datapath keeps its stale contents, which
      // are reloaded by the next accepted start anyway.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && (bus.repeat_n != '0)) begin
            pat_d   = bus.pat_in;
            rem_d   = bus.repeat_n;
            gap_d   = bus.gap_len;
            sh_d    = bus.pat_in;
            bidx_d  = BIDX_TOP;
            state_d = SEND;
          end
        end

        SEND: begin
          sh_d   = sh_q << 1;
          bidx_d = bidx_q - 1'b1;
          if (bidx_q == '0) begin
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              // Reload now so the first bit of the next repetition is ready
              // either next cycle (no gap) or the cycle GAP hands back.
              rem_d  = rem_q - 1'b1;
              sh_d   = pat_q;
              bidx_d = BIDX_TOP;
              if (gap_q != 4'd0) begin
                gcnt_d  = gap_q;
                state_d = GAP;
              end
            end
          end
        end

        GAP: begin
          gcnt_d = gcnt_q - 4'd1;
          // gcnt is loaded with a non-zero gap, so the <= also guards against
          // a corrupted zero ever stalling the FSM here.
          if (gcnt_q <= 4'd1) begin
            state_d = SEND;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs follow the state and shift register of the coming cycle.
    busy_d = (state_d != IDLE);
    vld_d  = (state_d == SEND);
    aout_d = vld_d & sh_d[W-1];
    sof_d  = vld_d && (bidx_d == BIDX_TOP);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      pat_q   <= '0;
      bidx_q  <= '0;
      rem_q   <= '0;
      gcnt_q  <= '0;
      gap_q   <= '0;
      aout_q  <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      pat_q   <= pat_d;
      bidx_q  <= bidx_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
      gap_q   <= gap_d;
      aout_q  <= aout_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.aout     = aout_q;
  assign bus.aout_vld = vld_q;
  assign bus.sof      = sof_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule : seq_pattern_tx
